cp0_exception_ctrl: RTL

// - Consumer end of the ID-stage decode flags: syscall, break, reserved-instruction, eret, mtc0 and mfc0.
// - Receives these flags, with address/overflow faults, at the MEM stage.
// - Holds the CP0 registers: BadVAddr, Count, Compare, Status, Cause, EPC and PRId.
// - Prioritises exceptions and interrupts, and drives pipeline flush plus the redirect PC.
// - Single clock; all CP0 state updates at the MEM->WB boundary.

---
 rtl/cp0_exception_ctrl_if.sv | 49 ++++
 rtl/cp0_exception_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception_ctrl_if.sv
// ---------------------------------------------------------------------------
// cp0_exception_ctrl_if
// Bundle between the MEM stage of the pipeline and the CP0 exception
// controller.
//   master : pipeline side. Drives the MEM-stage flags, the mtc0/mfc0 access
//            fields and the interrupt lines. Receives flush/redirect, read data
//            and the CP0 register views.
//   slave  : CP0 side, with the opposite directions.
// ---------------------------------------------------------------------------
interface cp0_exception_ctrl_if;
  logic        stall_i;
  logic        mtc0_we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic        syscall_i;
  logic        break_i;
  logic        reserve_i;
  logic        eret_i;
  logic        ov_i;
  logic        adel_i;
  logic        ades_i;
  logic        adel_if_i;
  logic [31:0] bad_addr_i;
  logic [31:0] pc_i;
  logic        in_ds_i;
  logic [5:0]  int_i;
  logic        flush_o;
  logic [31:0] newpc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;

  modport master (
    output stall_i, mtc0_we_i, waddr_i, wdata_i, raddr_i,
    output syscall_i, break_i, reserve_i, eret_i, ov_i,
    output adel_i, ades_i, adel_if_i, bad_addr_i, pc_i, in_ds_i, int_i,
    input  rdata_o, flush_o, newpc_o, status_o, cause_o, epc_o, timer_int_o
  );

  modport slave (
    input  stall_i, mtc0_we_i, waddr_i, wdata_i, raddr_i,
    input  syscall_i, break_i, reserve_i, eret_i, ov_i,
    input  adel_i, ades_i, adel_if_i, bad_addr_i, pc_i, in_ds_i, int_i,
    output rdata_o, flush_o, newpc_o, status_o, cause_o, epc_o, timer_int_o
  );
endinterface

// File: rtl/cp0_exception_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exception_ctrl
// MIPS-style CP0 at the MEM stage. It holds BadVAddr, Count, Compare, Status,
// Cause, EPC and PRId. It prioritises interrupts and exceptions, raises a
// combinational pipeline flush with the redirect PC, and commits all CP0 state
// at the MEM->WB edge.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : cp0_exception_ctrl_if.slave
//            inputs  : stall, mtc0 write (we/addr/data), mfc0 read address,
//                      exception flags, bad address, PC, delay-slot flag,
//                      6 hardware interrupt lines
//            outputs : mfc0 read data, flush, redirect PC, Status, Cause,
//                      EPC, timer interrupt
// ---------------------------------------------------------------------------
module cp0_exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] PRID_VAL   = 32'h0001_8000,
  parameter int          COUNT_DIV  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cp0_exception_ctrl_if.slave  bus
);

  localparam int               DIV_W        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(COUNT_DIV - 1);
  localparam logic [31:0]      STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0]      STATUS_WMASK = 32'h0000_FF03;

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_PRID     = 5'd15;

  logic [31:0]      r_badvaddr;
  logic [31:0]      r_count;
  logic [31:0]      r_compare;
  logic [31:0]      r_status;
  logic [31:0]      r_cause;
  logic [31:0]      r_epc;
  logic             r_timer_int;
  logic [DIV_W-1:0] r_div;

  logic [7:0]  w_cause_ip;
  logic [31:0] w_cause;
  logic        w_int_pend;
  logic        w_exc;
  logic [4:0]  w_code;
  logic        w_bad_upd;
  logic [31:0] w_bad_val;
  logic        w_eret;
  logic        w_flush;
  logic [31:0] w_newpc;
  logic        w_mtc0;
  logic [31:0] w_rdata;

  // r_cause[15] carries int_i[5]; the timer is merged in here so software and
  // the pending logic both see IP7 = hw5 | timer.
  assign w_cause_ip = {r_cause[15] | r_timer_int, r_cause[14:8]};
  assign w_cause    = {r_cause[31:16], w_cause_ip, r_cause[7:0]};
  assign w_int_pend = r_status[0] & ~r_status[1] & (|(w_cause_ip & r_status[15:8]));

  // Exception source selection, highest priority first. A fetch AdEL records
  // the PC as the bad address, because the fetch itself faulted.
  always_comb begin
    w_exc     = 1'b0;
    w_code    = 5'h00;
    w_bad_upd = 1'b0;
    w_bad_val = bus.bad_addr_i;
    if (!bus.stall_i) begin
      if (w_int_pend) begin
        w_exc  = 1'b1;
        w_code = 5'h00;
      end else if (bus.adel_i && bus.adel_if_i) begin
        w_exc     = 1'b1;
        w_code    = 5'h04;
        w_bad_upd = 1'b1;
        w_bad_val = bus.pc_i;
      end else if (bus.reserve_i) begin
        w_exc  = 1'b1;
        w_code = 5'h0A;
      end else if (bus.syscall_i) begin
        w_exc  = 1'b1;
        w_code = 5'h08;
      end else if (bus.break_i) begin
        w_exc  = 1'b1;
        w_code = 5'h09;
      end else if (bus.ov_i) begin
        w_exc  = 1'b1;
        w_code = 5'h0C;
      end else if (bus.adel_i) begin
        w_exc     = 1'b1;
        w_code    = 5'h04;
        w_bad_upd = 1'b1;
      end else if (bus.ades_i) begin
        w_exc     = 1'b1;
        w_code    = 5'h05;
        w_bad_upd = 1'b1;
      end
    end
  end

  assign w_eret  = ~bus.stall_i & bus.eret_i & ~w_exc;
  // Reset masks the flush so a reset landing on a faulting instruction does
  // not also redirect the front end.
  assign w_flush = ~rst & (w_exc | w_eret);
  assign w_newpc = rst    ? 32'h0 :
                   w_exc  ? EXC_VECTOR :
                   w_eret ? r_epc : 32'h0;
  assign w_mtc0  = bus.mtc0_we_i & ~bus.stall_i & ~w_flush;

  always_comb begin
    w_rdata = 32'h0;
    case (bus.raddr_i)
      A_BADVADDR: w_rdata = r_badvaddr;
      A_COUNT:    w_rdata = r_count;
      A_COMPARE:  w_rdata = r_compare;
      A_STATUS:   w_rdata = r_status;
      A_CAUSE:    w_rdata = w_cause;
      A_EPC:      w_rdata = r_epc;
      A_PRID:     w_rdata = PRID_VAL;
      default:    w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_badvaddr  <= 32'h0;
      r_count     <= 32'h0;
      r_compare   <= 32'h0;
      r_status    <= STATUS_RST;
      r_cause     <= 32'h0;
      r_epc       <= 32'h0;
      r_timer_int <= 1'b0;
      r_div       <= '0;
    end else begin
      // Count is free-running; a software write restarts the prescaler.
      if (w_mtc0 && bus.waddr_i == A_COUNT) begin
        r_count <= bus.wdata_i;
        r_div   <= '0;
      end else if (r_div == DIV_LAST) begin
        r_count <= r_count + 32'd1;
        r_div   <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end

      // Writing Compare acknowledges the timer, even if it matches this cycle.
      if (w_mtc0 && bus.waddr_i == A_COMPARE) begin
        r_compare   <= bus.wdata_i;
        r_timer_int <= 1'b0;
      end else if (r_compare != 32'h0 && r_count == r_compare) begin
        r_timer_int <= 1'b1;
      end

      r_cause[15:10] <= bus.int_i;

      if (w_exc) begin
        // Nested exceptions keep the original return point.
        if (!r_status[1]) begin
          r_epc       <= bus.in_ds_i ? (bus.pc_i - 32'd4) : bus.pc_i;
          r_cause[31] <= bus.in_ds_i;
        end
        r_cause[6:2] <= w_code;
        r_status[1]  <= 1'b1;
        if (w_bad_upd) r_badvaddr <= w_bad_val;
      end else if (w_eret) begin
        r_status[1] <= 1'b0;
      end else if (w_mtc0) begin
        case (bus.waddr_i)
          A_STATUS: r_status    <= (r_status & ~STATUS_WMASK) | (bus.wdata_i & STATUS_WMASK);
          A_CAUSE:  r_cause[9:8] <= bus.wdata_i[9:8];
          A_EPC:    r_epc       <= bus.wdata_i;
          default:  ;
        endcase
      end
    end
  end

  assign bus.rdata_o     = w_rdata;
  assign bus.flush_o     = w_flush;
  assign bus.newpc_o     = w_newpc;
  assign bus.status_o    = r_status;
  assign bus.cause_o     = w_cause;
  assign bus.epc_o       = r_epc;
  assign bus.timer_int_o = r_timer_int;

endmodule
